// File: rtl/life_pkg.sv
// Shared definitions for the viewport controller.
// Contents: commit FSM state enum, output width constants, and a signed
// clamp helper used for pending saturation and viewport limiting.
package life_pkg;

    localparam int SHIFT_W  = 16;
    localparam int SCROLL_W = 4;
    localparam int CALC_W   = 18;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        ZOOM,
        PAN,
        CLAMP
    } vp_state_t;

    function automatic calc_t clamp_s(calc_t v, calc_t lo, calc_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/viewport_ctrl_if.sv
// Button / vsync / viewport bundle between the user-input side and the
// controller.
//   master: drives buttons and vsync, receives the viewport.
//   slave : the controller; receives buttons and vsync, drives
//           shift_x, shift_y, scroll and commit_done.
interface viewport_ctrl_if;
    import life_pkg::*;

    logic                btn_left;
    logic                btn_right;
    logic                btn_up;
    logic                btn_down;
    logic                btn_zoom_in;
    logic                btn_zoom_out;
    logic                btn_center;
    logic                vsync;
    logic [SHIFT_W-1:0]  shift_x;
    logic [SHIFT_W-1:0]  shift_y;
    logic [SCROLL_W-1:0] scroll;
    logic                commit_done;

    modport master (
        output btn_left, btn_right, btn_up, btn_down,
        output btn_zoom_in, btn_zoom_out, btn_center, vsync,
        input  shift_x, shift_y, scroll, commit_done
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down,
        input  btn_zoom_in, btn_zoom_out, btn_center, vsync,
        output shift_x, shift_y, scroll, commit_done
    );

endinterface

// File: rtl/viewport_btn_repeat.sv
// btn_repeat: 2-FF synchroniser, press-edge detect and auto-repeat for one
// raw button. step is a registered one-cycle pulse, 3 cycles after the raw
// press. With REPEAT_EN set, a held button steps again REPEAT_DELAY cycles
// after the press, then every REPEAT_PERIOD cycles.
// Ports: clk, reset (async, active-high), btn (raw level), step (pulse).
module btn_repeat #(
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic step
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic             press;

    assign press = sync2 & ~prev;

    // cnt reaching zero while still held marks the next repeat step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            step  <= 1'b0;
            if (!sync2) begin
                cnt <= '0;
            end else if (press) begin
                step <= 1'b1;
                cnt  <= CNT_W'(REPEAT_DELAY - 1);
            end else if (REPEAT_EN) begin
                if (cnt == '0) begin
                    step <= 1'b1;
                    cnt  <= CNT_W'(REPEAT_PERIOD - 1);
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/viewport_ctrl.sv
// viewport_ctrl: button-driven pan/zoom for the VGA scan stage. Button steps
// accumulate into saturating pending deltas; on the vsync active edge they
// are committed through SNAP/ZOOM/PAN/CLAMP so all three outputs change in
// the same cycle, together with a commit_done pulse.
// Ports: clk, reset (async, active-high), vp (viewport_ctrl_if.slave).
module viewport_ctrl
    import life_pkg::*;
#(
    parameter int P_PARAM_N     = 1024,
    parameter int P_PARAM_M     = 1024,
    parameter int HSIZE         = 800,
    parameter int VSIZE         = 600,
    parameter bit VSPP          = 1'b0,
    parameter int MAX_SCROLL    = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int PEND_MAX      = 127
) (
    input logic           clk,
    input logic           reset,
    viewport_ctrl_if.slave vp
);

    localparam calc_t NX   = calc_t'(P_PARAM_N);
    localparam calc_t NY   = calc_t'(P_PARAM_M);
    localparam calc_t HS   = calc_t'(HSIZE);
    localparam calc_t VS   = calc_t'(VSIZE);
    localparam calc_t PMAX = calc_t'(PEND_MAX);
    localparam calc_t ZMAX = calc_t'(MAX_SCROLL);

    logic st_l, st_r, st_u, st_d, st_zi, st_zo, st_c;

    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_left  (.clk(clk), .reset(reset), .btn(vp.btn_left),  .step(st_l));
    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_right (.clk(clk), .reset(reset), .btn(vp.btn_right), .step(st_r));
    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_up    (.clk(clk), .reset(reset), .btn(vp.btn_up),    .step(st_u));
    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_down  (.clk(clk), .reset(reset), .btn(vp.btn_down),  .step(st_d));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_zin   (.clk(clk), .reset(reset), .btn(vp.btn_zoom_in),  .step(st_zi));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_zout  (.clk(clk), .reset(reset), .btn(vp.btn_zoom_out), .step(st_zo));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_ctr   (.clk(clk), .reset(reset), .btn(vp.btn_center),   .step(st_c));

    vp_state_t           state;
    logic                vs_prev;
    calc_t               pend_dx, pend_dy, pend_dz;
    logic                pend_c;
    calc_t               w_sx, w_sy, w_dx, w_dy, w_dz;
    logic                w_c;
    logic [SCROLL_W-1:0] w_sc;
    logic [SHIFT_W-1:0]  shift_x_q, shift_y_q;
    logic [SCROLL_W-1:0] scroll_q;
    logic                commit_q;

    logic                vs_act;
    calc_t               base_dx, base_dy, base_dz;
    logic                base_c;
    calc_t               nxt_dx, nxt_dy, nxt_dz;
    logic [SCROLL_W-1:0] zoom_sc;
    calc_t               wx_cur, wy_cur, wx_zoom, wy_zoom;
    calc_t               room_x, room_y, max_x, max_y;

    always_comb begin
        vs_act  = (vp.vsync == VSPP);
        // In SNAP the pending set restarts from zero, so a step landing in
        // that cycle is kept for the next frame instead of being dropped.
        base_dx = (state == SNAP) ? '0 : pend_dx;
        base_dy = (state == SNAP) ? '0 : pend_dy;
        base_dz = (state == SNAP) ? '0 : pend_dz;
        base_c  = (state == SNAP) ? 1'b0 : pend_c;
        nxt_dx  = clamp_s(base_dx + calc_t'(st_r) - calc_t'(st_l), -PMAX, PMAX);
        nxt_dy  = clamp_s(base_dy + calc_t'(st_d) - calc_t'(st_u), -PMAX, PMAX);
        nxt_dz  = clamp_s(base_dz + calc_t'(st_zi) - calc_t'(st_zo), -ZMAX, ZMAX);
        zoom_sc = SCROLL_W'(clamp_s(calc_t'(w_sc) + w_dz, '0, ZMAX));
        wx_cur  = HS >>> w_sc;
        wy_cur  = VS >>> w_sc;
        wx_zoom = HS >>> zoom_sc;
        wy_zoom = VS >>> zoom_sc;
        room_x  = NX - wx_cur;
        room_y  = NY - wy_cur;
        max_x   = room_x[CALC_W-1] ? '0 : room_x;
        max_y   = room_y[CALC_W-1] ? '0 : room_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vs_prev   <= 1'b0;
            pend_dx   <= '0;
            pend_dy   <= '0;
            pend_dz   <= '0;
            pend_c    <= 1'b0;
            w_sx      <= '0;
            w_sy      <= '0;
            w_dx      <= '0;
            w_dy      <= '0;
            w_dz      <= '0;
            w_c       <= 1'b0;
            w_sc      <= '0;
            shift_x_q <= '0;
            shift_y_q <= '0;
            scroll_q  <= '0;
            commit_q  <= 1'b0;
        end else begin
            vs_prev  <= vs_act;
            pend_dx  <= nxt_dx;
            pend_dy  <= nxt_dy;
            pend_dz  <= nxt_dz;
            pend_c   <= base_c | st_c;
            commit_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_act && !vs_prev) state <= SNAP;
                end
                SNAP: begin
                    w_sx  <= calc_t'(shift_x_q);
                    w_sy  <= calc_t'(shift_y_q);
                    w_sc  <= scroll_q;
                    w_dx  <= pend_dx;
                    w_dy  <= pend_dy;
                    w_dz  <= pend_dz;
                    w_c   <= pend_c;
                    state <= ZOOM;
                end
                ZOOM: begin
                    // Keep the viewport centre fixed across the zoom step.
                    w_sc  <= zoom_sc;
                    w_sx  <= w_sx + ((wx_cur - wx_zoom) >>> 1);
                    w_sy  <= w_sy + ((wy_cur - wy_zoom) >>> 1);
                    state <= PAN;
                end
                PAN: begin
                    if (w_c) begin
                        w_sx <= (NX - wx_cur) >>> 1;
                        w_sy <= (NY - wy_cur) >>> 1;
                    end else begin
                        w_sx <= w_sx + w_dx;
                        w_sy <= w_sy + w_dy;
                    end
                    state <= CLAMP;
                end
                CLAMP: begin
                    shift_x_q <= SHIFT_W'(clamp_s(w_sx, '0, max_x));
                    shift_y_q <= SHIFT_W'(clamp_s(w_sy, '0, max_y));
                    scroll_q  <= w_sc;
                    commit_q  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign vp.shift_x     = shift_x_q;
    assign vp.shift_y     = shift_y_q;
    assign vp.scroll      = scroll_q;
    assign vp.commit_done = commit_q;

endmodule

// File: tb/tb_viewport_ctrl.sv
// Self-checking bench for viewport_ctrl with repeat timing scaled to 20/5.
// A viewport model (integer arithmetic from the pan/zoom rules) tracks
// pending deltas and committed outputs; directed scenarios are followed by
// randomized button frames.
module tb_viewport_ctrl;

    localparam int N  = 1024;
    localparam int M  = 1024;
    localparam int HS = 800;
    localparam int VS = 600;
    localparam int MS = 4;
    localparam int PM = 127;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    viewport_ctrl_if vp();

    viewport_ctrl #(
        .P_PARAM_N(N), .P_PARAM_M(M), .HSIZE(HS), .VSIZE(VS), .VSPP(1'b0),
        .MAX_SCROLL(MS), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .PEND_MAX(PM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vp(vp)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int m_sx, m_sy, m_sc;
    int m_dx, m_dy, m_dz;
    int m_c;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int half_floor(input int a);
        return (a >= 0) ? a / 2 : -((1 - a) / 2);
    endfunction

    // Steps from a hold of h cycles: one at the press, one after RD cycles,
    // then one every RP cycles while still held.
    function automatic int n_steps(input int h);
        return 1 + ((h > RD) ? ((h - 1 - RD) / RP + 1) : 0);
    endfunction

    task automatic press(input int l, input int r, input int u, input int d,
                         input int zi, input int zo, input int c, input int hold);
        int n;
        n = n_steps(hold);
        for (int i = 0; i < n; i++) begin
            m_dx = clampi(m_dx + r - l, -PM, PM);
            m_dy = clampi(m_dy + d - u, -PM, PM);
        end
        m_dz = clampi(m_dz + zi - zo, -MS, MS);
        if (c != 0) m_c = 1;
        vp.btn_left     = (l != 0);
        vp.btn_right    = (r != 0);
        vp.btn_up       = (u != 0);
        vp.btn_down     = (d != 0);
        vp.btn_zoom_in  = (zi != 0);
        vp.btn_zoom_out = (zo != 0);
        vp.btn_center   = (c != 0);
        ticks(hold);
        vp.btn_left     = 1'b0;
        vp.btn_right    = 1'b0;
        vp.btn_up       = 1'b0;
        vp.btn_down     = 1'b0;
        vp.btn_zoom_in  = 1'b0;
        vp.btn_zoom_out = 1'b0;
        vp.btn_center   = 1'b0;
        ticks(8);
    endtask

    // Drive one vsync pulse (low-active) and check the commit timing:
    // old viewport at E+4, new viewport with commit_done at E+5, pulse gone at E+6.
    task automatic frame(input string tag);
        int nsc, nsx, nsy, wn, hn;
        nsc = clampi(m_sc + m_dz, 0, MS);
        wn  = HS >> nsc;
        hn  = VS >> nsc;
        nsx = m_sx + half_floor((HS >> m_sc) - wn);
        nsy = m_sy + half_floor((VS >> m_sc) - hn);
        if (m_c != 0) begin
            nsx = half_floor(N - wn);
            nsy = half_floor(M - hn);
        end else begin
            nsx = nsx + m_dx;
            nsy = nsy + m_dy;
        end
        nsx = clampi(nsx, 0, (N - wn > 0) ? N - wn : 0);
        nsy = clampi(nsy, 0, (M - hn > 0) ? M - hn : 0);

        vp.vsync = 1'b0;
        ticks(4);
        check_val({tag, "_e4_sx"}, int'(vp.shift_x), m_sx);
        check_val({tag, "_e4_sy"}, int'(vp.shift_y), m_sy);
        check_val({tag, "_e4_sc"}, int'(vp.scroll), m_sc);
        check_val({tag, "_e4_cd"}, int'(vp.commit_done), 0);
        tick();
        check_val({tag, "_sx"}, int'(vp.shift_x), nsx);
        check_val({tag, "_sy"}, int'(vp.shift_y), nsy);
        check_val({tag, "_sc"}, int'(vp.scroll), nsc);
        check_val({tag, "_cd"}, int'(vp.commit_done), 1);
        tick();
        check_val({tag, "_e6_cd"}, int'(vp.commit_done), 0);
        ticks(6);
        vp.vsync = 1'b1;
        ticks(6);

        m_sx = nsx;
        m_sy = nsy;
        m_sc = nsc;
        m_dx = 0;
        m_dy = 0;
        m_dz = 0;
        m_c  = 0;
    endtask

    initial begin
        int pulses;
        int np;
        int b[7];

        m_sx = 0; m_sy = 0; m_sc = 0;
        m_dx = 0; m_dy = 0; m_dz = 0; m_c = 0;

        reset           = 1'b1;
        vp.vsync        = 1'b1;
        vp.btn_left     = 1'b0;
        vp.btn_right    = 1'b0;
        vp.btn_up       = 1'b0;
        vp.btn_down     = 1'b0;
        vp.btn_zoom_in  = 1'b0;
        vp.btn_zoom_out = 1'b0;
        vp.btn_center   = 1'b0;
        ticks(3);
        check_val("rst_sx", int'(vp.shift_x), 0);
        check_val("rst_sy", int'(vp.shift_y), 0);
        check_val("rst_sc", int'(vp.scroll), 0);
        check_val("rst_cd", int'(vp.commit_done), 0);
        reset = 1'b0;
        ticks(4);

        frame("idle0");
        frame("idle1");
        frame("idle2");

        press(0, 1, 0, 0, 0, 0, 0, 10);
        frame("right10");
        check_val("right10_const_sx", int'(vp.shift_x), 1);

        press(1, 0, 0, 0, 0, 0, 0, 2);
        frame("back0");

        press(0, 0, 0, 0, 1, 0, 0, 3);
        frame("zin");
        check_val("zin_const_sx", int'(vp.shift_x), 200);
        check_val("zin_const_sy", int'(vp.shift_y), 150);
        check_val("zin_const_sc", int'(vp.scroll), 1);

        press(0, 0, 0, 0, 1, 0, 1, 3);
        frame("center2");
        check_val("center2_const_sx", int'(vp.shift_x), 412);
        check_val("center2_const_sy", int'(vp.shift_y), 437);

        for (int i = 0; i < 3; i++) press(0, 0, 0, 0, 1, 0, 0, 2);
        frame("zmax");
        press(0, 0, 0, 0, 1, 0, 0, 2);
        frame("zmax_again");
        check_val("zmax_const_sc", int'(vp.scroll), 4);

        press(1, 1, 0, 0, 0, 0, 0, 4);
        frame("lr_cancel");

        for (int i = 0; i < 4; i++) press(0, 0, 0, 0, 0, 1, 0, 2);
        frame("zmin");
        press(0, 1, 0, 0, 0, 0, 0, 700);
        frame("right_sat1");
        press(0, 1, 0, 0, 0, 0, 0, 700);
        frame("right_sat2");
        check_val("xmax_const_sx", int'(vp.shift_x), 224);
        press(0, 1, 0, 0, 0, 0, 0, 2);
        frame("xmax_right");
        check_val("xmax_right_const_sx", int'(vp.shift_x), 224);
        press(1, 0, 0, 0, 0, 0, 0, RD + 300 * RP);
        frame("left_sat");
        check_val("left_sat_const_sx", int'(vp.shift_x), 97);

        // Right step lands in the SNAP cycle: it must carry to the next frame.
        vp.btn_right = 1'b1;
        tick();
        vp.btn_right = 1'b0;
        tick();
        frame("snap_step");
        m_dx = clampi(m_dx + 1, -PM, PM);
        frame("snap_next");

        for (int f = 0; f < 15; f++) begin
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                for (int k = 0; k < 7; k++) b[k] = ($urandom_range(0, 3) == 0) ? 1 : 0;
                press(b[0], b[1], b[2], b[3], b[4], b[5], b[6], $urandom_range(1, 45));
            end
            frame($sformatf("rnd%0d", f));
        end

        // Reset during ZOOM with a zoom pending: no commit, outputs to zero.
        press(0, 0, 0, 0, 1, 0, 0, 2);
        press(0, 1, 0, 1, 0, 0, 0, 3);
        vp.vsync = 1'b0;
        ticks(2);
        reset = 1'b1;
        #1;
        check_val("abort_sx", int'(vp.shift_x), 0);
        check_val("abort_sy", int'(vp.shift_y), 0);
        check_val("abort_sc", int'(vp.scroll), 0);
        check_val("abort_cd", int'(vp.commit_done), 0);
        vp.vsync = 1'b1;
        ticks(2);
        reset = 1'b0;
        m_sx = 0; m_sy = 0; m_sc = 0;
        m_dx = 0; m_dy = 0; m_dz = 0; m_c = 0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vp.commit_done) pulses++;
        end
        check_val("abort_no_pulse", pulses, 0);
        frame("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/viewport_ctrl.md
# viewport_ctrl

Pan/zoom controller that drives the `shift_x`, `shift_y` and `scroll` inputs of the VGA scan stage from user buttons. Button events are debounced into per-frame pending deltas with auto-repeat. They are committed atomically during the vertical sync pulse, so a frame is never drawn with a mixed viewport. Sits directly upstream of the VGA scanner and shares its clock domain and `vsync`.

## Interface
Parameters:
- `P_PARAM_N`, 1024: grid width in cells.
- `P_PARAM_M`, 1024: grid height in cells.
- `HSIZE`, 800: visible horizontal pixels.
- `VSIZE`, 600: visible vertical pixels.
- `VSPP`, 0: vsync active polarity (0 = low-active).
- `MAX_SCROLL`, 4: largest zoom shift.
- `REPEAT_DELAY`, 25_000_000: hold cycles before auto-repeat starts.
- `REPEAT_PERIOD`, 5_000_000: cycles between repeated steps.
- `PEND_MAX`, 127: saturation of the pending pan magnitude.

Ports:
- `clk` in 1: pixel clock, same as the VGA scanner.
- `reset` in 1: asynchronous, active-high.
- `btn_left`, `btn_right`, `btn_up`, `btn_down` in 1 each: raw level, asynchronous.
- `btn_zoom_in`, `btn_zoom_out` in 1 each: raw level, asynchronous.
- `btn_center` in 1: raw level, asynchronous.
- `vsync` in 1: from the VGA scanner.
- `shift_x` out 16: first visible cell column.
- `shift_y` out 16: first visible cell row.
- `scroll` out 4: zoom shift, one cell = 2^scroll pixels.
- `commit_done` out 1: one-cycle pulse when new outputs take effect.

## Operation
- Each button passes through a 2-FF synchroniser, then rising-edge detection, then an auto-repeat counter.
- A button emits one step on its press edge.
- While the button stays held, it emits again after `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles.
- Release clears that button's counter.
- Zoom and center buttons have no repeat. They step on the press edge only.
- Pending registers:
  - `pend_dx`, `pend_dy`: signed, saturate at ±`PEND_MAX`.
  - `pend_dz`: signed, saturates at ±`MAX_SCROLL`.
  - `pend_center`: flag.
- Opposite steps in the same cycle cancel.
- Commit FSM states:
  - IDLE → SNAP on the vsync active edge (previous sample inactive, current sample active).
  - SNAP: copy pending into working registers and clear pending. A step arriving in the SNAP cycle goes into the freshly cleared pending set and is not lost.
  - ZOOM: new scroll = clamp(scroll + dz, 0, `MAX_SCROLL`). Adjust the shift to keep the viewport centre fixed: sx += (w_old − w_new)/2, where w = `HSIZE` >> scroll; the same rule applies to sy with `VSIZE`. Use signed 18-bit arithmetic with an arithmetic shift for /2.
  - PAN: if center is set, sx = (`P_PARAM_N` − w_new)/2 and sy = (`P_PARAM_M` − h_new)/2, and dx/dy are ignored. Otherwise sx += dx and sy += dy.
  - CLAMP: sx = clamp(sx, 0, max(0, `P_PARAM_N` − w_new)); sy is clamped likewise with `P_PARAM_M` and h_new. Write `shift_x`, `shift_y`, `scroll` together and pulse `commit_done`. Return to IDLE.
- A vsync edge seen outside IDLE is ignored.
- Outputs are only ever written in CLAMP.

## Timing
- Reset values: `shift_x`=0, `shift_y`=0, `scroll`=0, `commit_done`=0. Pending registers, repeat counters and synchronisers clear. State = IDLE.
- Button-to-step latency: 3 cycles (2 synchroniser stages plus the edge register).
- The vsync edge is detected in cycle E. SNAP is E+1, ZOOM is E+2, PAN is E+3, CLAMP is E+4.
- New outputs and `commit_done` are visible from E+5. The sync pulse is far longer than 5 cycles, so the update completes before the visible region.
- Reset asserted mid-commit aborts the commit. Outputs return to their reset values immediately; no partial update occurs.

## Structure
- Shared package `life_pkg`:
  - FSM state enum `vp_state_t` (IDLE, SNAP, ZOOM, PAN, CLAMP).
  - Width constants `SHIFT_W`=16 and `SCROLL_W`=4.
- Sub-module `btn_repeat`: synchroniser, edge detection and repeat counter. Instantiated 4× for directions. Zoom and center use the same module with repeat disabled via a parameter.

## Test plan
Default parameters apply. Scale the repeat parameters to 20/5 in sim.
- Reset, then run 3 frames with no buttons pressed → outputs stay (0,0,0) and `commit_done` pulses once per frame.
- `btn_right` held 10 cycles → `shift_x` stays 0 until E+5 of the next vsync edge, then becomes 1. `shift_y` stays 0.
- `btn_zoom_in` tap from (0,0,0) → `scroll`=1, `shift_x`=200, `shift_y`=150.
- At `scroll`=0 with `shift_x`=224 (the maximum, 1024−800), press right → `shift_x` stays 224. Hold left for 300 repeat steps → `pend_dx` saturates at −127 and the frame commit gives 97.
- `btn_left` and `btn_right` pressed in the same cycle → no change. `btn_zoom_in` at `scroll`=4 → no change. `btn_center` at `scroll`=2 → `shift_x`=412, `shift_y`=437.
- Assert `reset` in the ZOOM cycle after a pending zoom → outputs (0,0,0), no `commit_done` pulse, pending cleared.
